// File: rtl/adc_spi_reader.sv
// ADC front-end: paces conversions from a sample timer, drives CNV/SCK and captures 24-bit samples.
// Optional build macro ADC_TEST_PATTERN_EN replaces captured data with a 24-bit ramp.
module adc_spi_reader #(
    parameter int SAMPLE_PERIOD = 200,
    parameter int CONV_CYCLES   = 60,
    parameter int SCK_DIV       = 2,
    parameter int DATA_BITS     = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_adc_sdo,
    output logic                 o_adc_cnv,
    output logic                 o_adc_sck,
    output logic [DATA_BITS-1:0] o_adc_data,
    output logic                 o_adc_valid,
    output logic                 o_busy,
    output logic                 o_overrun
);

    localparam int HALF_PHASES = 2 * DATA_BITS;
    localparam int CNT_MAX     = (CONV_CYCLES > SCK_DIV) ? CONV_CYCLES : SCK_DIV;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);
    localparam int PH_W        = $clog2(HALF_PHASES);
    localparam int TMR_W       = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_READ,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [TMR_W-1:0]     r_timer;
    logic [CNT_W-1:0]     r_cnt;
    logic [PH_W-1:0]      r_phase;
    logic                 r_cnv;
    logic                 r_sck;
    logic                 r_valid;
    logic                 r_busy;
    logic [DATA_BITS-1:0] r_data;

    logic w_tick;
    logic w_conv_end;
    logic w_half_end;
    logic w_read_end;
    logic w_cnv_nxt;
    logic w_sck_nxt;
    logic w_valid_nxt;
    logic w_busy_nxt;
    logic w_overrun;

    // Sample timer: free-runs while enabled, parked at zero otherwise.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_timer <= '0;
        end else if (!i_en) begin
            r_timer <= '0;
        end else if (r_timer == TMR_W'(SAMPLE_PERIOD - 1)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_tick     = (r_timer == '0) & i_en;
    assign w_conv_end = (r_cnt == CNT_W'(CONV_CYCLES - 1));
    assign w_half_end = (r_cnt == CNT_W'(SCK_DIV - 1));
    assign w_read_end = w_half_end && (r_phase == PH_W'(HALF_PHASES - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_CONV;
            S_CONV:  if (w_conv_end) w_state_nxt = S_READ;
            S_READ:  if (w_read_end) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the output flops, so the pins come straight from registers.
    always_comb begin
        w_cnv_nxt   = (w_state_nxt == S_CONV);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_valid_nxt = (w_state_nxt == S_DONE);
        w_sck_nxt   = 1'b0;
        if (w_state_nxt == S_READ) begin
            w_sck_nxt = (r_state == S_READ && w_half_end) ? ~r_sck : r_sck;
        end
        w_overrun   = w_tick & (r_state != S_IDLE);
    end

    // r_cnt times CONV, then the cycles within one SCK half-period; r_phase counts half-periods.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else begin
            if (w_state_nxt != r_state || r_state == S_IDLE || r_state == S_DONE) begin
                r_cnt <= '0;
            end else if (r_state == S_READ && w_half_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state != S_READ) begin
                r_phase <= '0;
            end else if (w_half_end) begin
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnv   <= 1'b0;
            r_sck   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cnv   <= w_cnv_nxt;
            r_sck   <= w_sck_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

`ifdef ADC_TEST_PATTERN_EN
    logic [DATA_BITS-1:0] r_ramp;
    logic                 w_unused_sdo;

    assign w_unused_sdo = i_adc_sdo;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ramp <= '0;
            r_data <= '0;
        end else if (w_state_nxt == S_DONE) begin
            r_data <= r_ramp;
            r_ramp <= r_ramp + 1'b1;
        end
    end
`else
    logic [DATA_BITS-1:0] r_shift;

    // Sample SDO on the same edge that raises SCK; bits arrive MSB first.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_shift <= '0;
        end else if (w_sck_nxt && !r_sck) begin
            r_shift <= {r_shift[DATA_BITS-2:0], i_adc_sdo};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_data <= '0;
        end else if (w_state_nxt == S_DONE) begin
            r_data <= r_shift;
        end
    end
`endif

    assign o_adc_cnv   = r_cnv;
    assign o_adc_sck   = r_sck;
    assign o_adc_data  = r_data;
    assign o_adc_valid = r_valid;
    assign o_busy      = r_busy;
    // Flags the dropped tick in the very cycle it occurs.
    assign o_overrun   = w_overrun;

endmodule

// File: tb/tb_adc_spi_reader.sv
// Bench for adc_spi_reader: two instances (default period, and period 100 to force overruns)
// checked every cycle against a timeline model derived from the tick-relative latencies.
module tb_adc_spi_reader;

    localparam int CONV = 60;
    localparam int DIV  = 2;
    localparam int READ = 48 * DIV;
    localparam int LAT  = CONV + READ + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  sdo = '0;
    logic [1:0]  cnv, sck, valid, busy, ovr;
    logic [23:0] data [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adc_spi_reader dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_adc_sdo(sdo[0]),
        .o_adc_cnv(cnv[0]), .o_adc_sck(sck[0]), .o_adc_data(data[0]),
        .o_adc_valid(valid[0]), .o_busy(busy[0]), .o_overrun(ovr[0])
    );

    adc_spi_reader #(.SAMPLE_PERIOD(100)) dut_ovr (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_adc_sdo(sdo[1]),
        .o_adc_cnv(cnv[1]), .o_adc_sck(sck[1]), .o_adc_data(data[1]),
        .o_adc_valid(valid[1]), .o_busy(busy[1]), .o_overrun(ovr[1])
    );

    // Sample words served by the ADC models; the first six are the directed set.
    logic [23:0] words [64];

    // Timeline model state, one slot per instance.
    int          sp_m [2] = '{200, 100};
    int          en_cnt [2];
    int          t0 [2];
    bit          act [2];
    int          widx [2];
    logic [23:0] cur_word [2];
    logic [23:0] last_data [2];
    logic [23:0] ramp_m [2];
    int          cyc = 0;

    // ADC serial model: presents the next bit after each SCK rise, restarting at each CNV rise.
    logic [23:0] drv_word [2];
    int          bitcnt [2];
    logic [1:0]  cnv_pd = '0;
    logic [1:0]  sck_pd = '0;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                bitcnt[i] = 0;
            end else begin
                if (cnv[i] && !cnv_pd[i]) begin
                    bitcnt[i]   = 0;
                    drv_word[i] = cur_word[i];
                end
                if (sck[i] && !sck_pd[i]) bitcnt[i] = bitcnt[i] + 1;
            end
            cnv_pd[i] = cnv[i];
            sck_pd[i] = sck[i];
            sdo[i] = (bitcnt[i] < 24) ? drv_word[i][23 - bitcnt[i]] : 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests = tests + 1;
        if (act_v !== exp_v) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
        end
    endtask

    // Per-cycle expectation from the latency rules: everything is a function of
    // the distance d between the current cycle and the last accepted tick.
    task automatic model_check();
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            logic [28:0] got, expv;
            int d;
            bit tick, m_busy, m_cnv, m_sck, m_valid;
            got = {cnv[i], sck[i], valid[i], busy[i], ovr[i], data[i]};
            if (!rst) begin
                en_cnt[i] = 0;
                act[i] = 0;
                last_data[i] = '0;
                ramp_m[i] = '0;
                expv = '0;
            end else begin
                d       = cyc - t0[i];
                m_cnv   = act[i] && d >= 1 && d <= CONV;
                m_sck   = act[i] && d > CONV && d <= CONV + READ && (((d - CONV - 1) / DIV) % 2 == 1);
                m_valid = act[i] && d == LAT;
                m_busy  = act[i] && d >= 1 && d <= LAT;
                tick    = en && (en_cnt[i] % sp_m[i] == 0);
                if (m_valid) begin
`ifdef ADC_TEST_PATTERN_EN
                    last_data[i] = ramp_m[i];
                    ramp_m[i] = ramp_m[i] + 24'd1;
`else
                    last_data[i] = cur_word[i];
`endif
                end
                expv = {m_cnv, m_sck, m_valid, m_busy, tick && m_busy, last_data[i]};
                if (tick && !m_busy) begin
                    act[i] = 1;
                    t0[i] = cyc;
                    cur_word[i] = words[widx[i] % 64];
                    widx[i] = widx[i] + 1;
                end
                en_cnt[i] = en ? en_cnt[i] + 1 : 0;
            end
            tests = tests + 1;
            if (got !== expv) begin
                fails = fails + 1;
                $display("FAIL dut%0d outputs cyc %0d: got %h expected %h (cnv,sck,valid,busy,ovr,data)",
                         i, cyc, got, expv);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
    endtask

    task automatic drive_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnv_cnt, cnv_first, cnv_last, rises, rise_first, rise_last, ov0;
        int v0 [8];
        int v1 [8];
        int o1 [8];
        int nv0, nv1, no1, found;
        logic sp;
        logic [23:0] expd;

        rst = 1'b0;
        en  = 1'b0;
        words[0] = 24'h800001; words[1] = 24'h7FFFFF; words[2] = 24'h000000;
        words[3] = 24'hFFFFFF; words[4] = 24'h123456; words[5] = 24'hA5A5A5;
        for (int i = 6; i < 64; i++) words[i] = 24'($urandom);
        for (int i = 0; i < 2; i++) begin
            widx[i] = 0; t0[i] = 0; act[i] = 0; en_cnt[i] = 0;
            cur_word[i] = '0; drv_word[i] = '0; bitcnt[i] = 0;
        end

        repeat (5) step();
        chk("reset outputs dut0", 32'({cnv[0], sck[0], valid[0], busy[0], ovr[0], data[0]}), 32'd0);
        drive_next(); rst = 1'b1;
        repeat (3) step();

        // Continuous enable for six samples; tick lands in cycle 0.
        drive_next(); en = 1'b1;
        step();
        cnv_cnt = 0; cnv_first = -1; cnv_last = -1;
        rises = 0; rise_first = -1; rise_last = -1; ov0 = 0;
        nv0 = 0; nv1 = 0; no1 = 0;
        sp = sck[0];
        for (int n = 1; n <= 1160; n++) begin
            step();
            if (n <= 156 && cnv[0]) begin
                cnv_cnt++;
                if (cnv_first < 0) cnv_first = n;
                cnv_last = n;
            end
            if (n <= 157 && sck[0] && !sp) begin
                rises++;
                if (rise_first < 0) rise_first = n;
                rise_last = n;
            end
            sp = sck[0];
            if (ovr[0]) ov0++;
            if (valid[0] && nv0 < 8) begin
`ifdef ADC_TEST_PATTERN_EN
                expd = 24'(nv0);
`else
                expd = words[nv0];
`endif
                chk("first-run data dut0", 32'(data[0]), 32'(expd));
                v0[nv0] = n; nv0++;
            end
            if (valid[1] && nv1 < 8) begin
`ifdef ADC_TEST_PATTERN_EN
                expd = 24'(nv1);
`else
                expd = words[nv1];
`endif
                chk("first-run data dut1", 32'(data[1]), 32'(expd));
                v1[nv1] = n; nv1++;
            end
            if (ovr[1] && no1 < 8) begin
                o1[no1] = n; no1++;
            end
        end
        chk("cnv high cycles", cnv_cnt, 60);
        chk("cnv first cycle", cnv_first, 1);
        chk("cnv last cycle", cnv_last, 60);
        chk("sck rises", rises, 24);
        chk("sck first rise", rise_first, 63);
        chk("sck last rise", rise_last, 155);
        chk("dut0 overruns", ov0, 0);
        chk("dut0 valid count", nv0, 6);
        chk("dut0 first valid latency", v0[0], 157);
        for (int j = 1; j < 6 && j < nv0; j++) chk("dut0 valid spacing", v0[j] - v0[j-1], 200);
        chk("dut1 valid count", nv1, 6);
        for (int j = 0; j < 6 && j < nv1; j++) chk("dut1 valid cycle", v1[j], 157 + 200 * j);
        chk("dut1 overrun count", no1, 6);
        for (int j = 0; j < 6 && j < no1; j++) chk("dut1 overrun cycle", o1[j], 100 + 200 * j);

        // Drop enable in the middle of READ (tick at 1200, READ spans 1261..1356).
        for (int n = 1161; n <= 1300; n++) step();
        drive_next(); en = 1'b0;
        nv0 = 0; cnv_cnt = 0; found = -1;
        for (int n = 1301; n <= 1600; n++) begin
            step();
            if (valid[0]) begin nv0++; found = n; end
            if (cnv[0] || cnv[1]) cnv_cnt++;
        end
        chk("valid after en drop count", nv0, 1);
        chk("valid after en drop cycle", found, 1357);
        chk("cnv while disabled", cnv_cnt, 0);
        chk("busy after drain", 32'(busy), 32'd0);
        drive_next(); en = 1'b1;
        step();
        chk("cnv in re-enable tick cycle", 32'(cnv), 32'd0);
        step();
        chk("cnv after re-enable", 32'(cnv), 32'd3);

        // Reset once ten bits have been clocked in.
        rises = 0; sp = sck[0];
        for (int n = 0; n < 200 && rises < 10; n++) begin
            step();
            if (sck[0] && !sp) rises++;
            sp = sck[0];
        end
        chk("reached bit 10", rises, 10);
        drive_next(); rst = 1'b0;
        #1;
        chk("outputs at reset", 32'({cnv, sck, valid, busy}), 32'd0);
        repeat (3) step();
        drive_next(); rst = 1'b1;
        step();
        found = -1;
        for (int m = 1; m <= 300 && found < 0; m++) begin
            step();
            if (valid[0]) found = m;
        end
        chk("latency after reset", found, 157);
        repeat (450) step();

        // Random enable segments with occasional resets.
        for (int s = 0; s < 14; s++) begin
            int len;
            drive_next();
            if ($urandom_range(0, 5) == 0) begin
                rst = 1'b0;
                step(); step();
                drive_next();
                rst = 1'b1;
            end
            en  = (s % 2 == 0);
            len = en ? $urandom_range(50, 700) : $urandom_range(1, 250);
            for (int k = 0; k < len; k++) step();
        end
        drive_next(); en = 1'b0;
        repeat (250) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Front-end ADC capture block that produces the raw 24-bit sample stream consumed by the moving-sum averager.
- Paces conversions from a sample timer and drives the ADC CNV/SCK pins. It shifts in 24-bit two's-complement data MSB-first and emits each sample with a one-cycle valid strobe.
- Sits between the ADC pins and the averager's data/valid inputs. The offset-binary conversion is done downstream, not here.

Parameters:
- SAMPLE_PERIOD, 200: i_clk cycles per conversion (1 MSPS at 200 MHz); minimum CONV_CYCLES+48*SCK_DIV+2.
- CONV_CYCLES, 60: i_clk cycles o_adc_cnv is held high (ADC conversion time).
- SCK_DIV, 2: i_clk cycles per SCK half-period; minimum 1.
- DATA_BITS, 24: bits per sample. Only 24 is supported.

Ports:
- i_clk  in  1  system clock, 200 MHz
- i_rst  in  1  asynchronous, active-low reset
- i_en  in  1  enables the sample timer
- i_adc_sdo  in  1  ADC serial data out
- o_adc_cnv  out  1  ADC convert-start
- o_adc_sck  out  1  ADC serial clock, idles low
- o_adc_data  out  24  last captured sample, two's complement
- o_adc_valid  out  1  one-cycle strobe when o_adc_data updates
- o_busy  out  1  high whenever state != IDLE
- o_overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, shift register 0.
  - Reset mid-transaction aborts immediately; CNV and SCK go low asynchronously.
- Sample timer:
  - While i_en=1 it counts 0..SAMPLE_PERIOD-1 and wraps.
  - While i_en=0 it is cleared to 0 and holds.
  - tick = (timer==0) & i_en.
  - The first tick occurs in the first cycle i_en is sampled high.
- State machine: IDLE, CONV, READ, DONE.
  - IDLE: on tick go to CONV, otherwise stay.
  - CONV: o_adc_cnv=1 for exactly CONV_CYCLES cycles, then go to READ.
  - READ: o_adc_cnv=0. Generate 24 SCK periods; each is SCK_DIV cycles low then SCK_DIV cycles high.
    - On each i_clk edge where o_adc_sck goes 0->1, shift i_adc_sdo into the LSB of the shift register (MSB first overall).
    - After the 24th high phase, go to DONE. SCK returns low.
  - DONE: o_adc_data <= shift register and o_adc_valid=1 for this single cycle, then go to IDLE.
  - o_adc_data holds its value between strobes.
- Latency: for a tick in cycle T:
  - CNV is high in cycles T+1..T+CONV_CYCLES.
  - SCK is active in cycles T+CONV_CYCLES+1..T+CONV_CYCLES+48*SCK_DIV.
  - o_adc_valid is high in cycle T+CONV_CYCLES+48*SCK_DIV+1. With defaults this is T+157.
- Overrun: a tick arriving while state != IDLE is dropped and o_overrun pulses for 1 cycle. The transaction in flight is unaffected.
- i_en deasserted mid-transaction: the transaction completes and valid is still issued. No further ticks occur until i_en returns high.
- Back-to-back: DONE->IDLE takes one cycle, so a tick may be accepted in the cycle after DONE.
- o_adc_sck and o_adc_cnv are driven directly from flops, glitch-free.

Optional Feature:
- Macro ADC_TEST_PATTERN_EN.
- Defined:
  - The full CNV/SCK sequence still runs.
  - In DONE, o_adc_data is loaded from an internal 24-bit ramp counter instead of the shift register. The counter resets to 0x000000, increments by 1 after each DONE, and wraps 0xFFFFFF->0x000000.
  - i_adc_sdo is ignored.
- Not defined: no ramp counter is present; data comes from i_adc_sdo.

Test Plan:
- Reset then i_en=1 with an SDO model returning 0x800001 -> CNV high for 60 cycles; 24 SCK pulses of period 4; o_adc_valid in cycle T+157; o_adc_data=0x800001.
- Continuous i_en=1 for 5 samples, model returning 0x7FFFFF then 0x000000, 0xFFFFFF, 0x123456, 0xA5A5A5 -> valid strobes exactly 200 cycles apart; each value captured correctly; o_overrun never asserted.
- SAMPLE_PERIOD=100 (below the 158 required) -> each alternate tick dropped; o_overrun pulses at the dropped ticks; valid strobes 200 cycles apart.
- i_en dropped during READ -> the current sample completes and valid is issued; no CNV afterwards; re-enable -> CNV rises in the next cycle.
- i_rst asserted during READ at bit 10 -> CNV/SCK/valid/busy go to 0 at once; after release the next sample is correct with no stale bits.
- ADC_TEST_PATTERN_EN defined, 3 samples -> o_adc_data = 0x000000, 0x000001, 0x000002 regardless of SDO.
